bcd_scan_display: RTL

Downstream consumer of the BCD counter chain: takes a packed vector of BCD digits (one nibble per counter stage) and drives a multiplexed, common-anode seven-segment display. It time-multiplexes the digits with a programmable per-digit dwell and inserts an anti-ghosting blank gap at the start of each digit slot. It also provides leading-zero blanking and captures a per-frame snapshot so a counter ripple mid-scan never tears the displayed value.

---
 rtl/seg_pkg.sv | 28 ++
 rtl/bcd_to_seg.sv | 32 +++
 rtl/bcd_scan_display.sv | 82 ++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Active-low seven-segment constants and segment bit ordering shared by the display path.
package seg_pkg;

  typedef logic [6:0] seg_t;

  // seg_t bit positions, so the vector reads {g,f,e,d,c,b,a}
  localparam int SEG_BIT_A = 0;
  localparam int SEG_BIT_B = 1;
  localparam int SEG_BIT_C = 2;
  localparam int SEG_BIT_D = 3;
  localparam int SEG_BIT_E = 4;
  localparam int SEG_BIT_F = 5;
  localparam int SEG_BIT_G = 6;

  localparam seg_t SEG_0    = 7'h40;
  localparam seg_t SEG_1    = 7'h79;
  localparam seg_t SEG_2    = 7'h24;
  localparam seg_t SEG_3    = 7'h30;
  localparam seg_t SEG_4    = 7'h19;
  localparam seg_t SEG_5    = 7'h12;
  localparam seg_t SEG_6    = 7'h02;
  localparam seg_t SEG_7    = 7'h78;
  localparam seg_t SEG_8    = 7'h00;
  localparam seg_t SEG_9    = 7'h10;
  localparam seg_t SEG_DASH = 7'h3F;
  localparam seg_t SEG_OFF  = 7'h7F;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-low segment pattern; invalid codes show a dash.
// A set blank input overrides the nibble and turns every segment off.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (blank) begin
      seg = SEG_OFF;
    end else begin
      case (nib)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/bcd_scan_display.sv
// Multiplexed common-anode display scanner with per-frame snapshot, blank gap and leading-zero blanking.
// All outputs registered (one cycle behind scan state); free-running, no backpressure.
module bcd_scan_display
  import seg_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   bcd,
  input  logic                  lzb_en,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] snap;
  logic                lzb_snap;

  logic                slot_end;
  logic                frame_end;
  logic                zero_run;
  logic [DIGITS-1:0]   lz_blank;
  logic [3:0]          cur_nib;
  logic                cur_blank;
  logic [6:0]          cur_seg;

  assign slot_end  = (cnt == CNT_W'(SCAN_DIV - 1));
  assign frame_end = slot_end && (idx == IDX_W'(DIGITS - 1));

  // Walk down from the top digit; a digit blanks only while every nibble at or above it is zero.
  always_comb begin
    zero_run = 1'b1;
    lz_blank = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run    = zero_run & (snap[4*i +: 4] == 4'h0);
      lz_blank[i] = lzb_snap & zero_run & (i != 0);
    end
  end

  assign cur_nib   = snap[{idx, 2'b00} +: 4];
  assign cur_blank = lz_blank[idx];

  bcd_to_seg u_dec (
    .nib   (cur_nib),
    .blank (cur_blank),
    .seg   (cur_seg)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      idx        <= '0;
      snap       <= '0;
      lzb_snap   <= 1'b0;
      seg        <= SEG_OFF;
      an         <= '1;
      frame_tick <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) begin
        idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end
      // Snapshot only at frame boundary so a mid-scan counter ripple never tears the display.
      if (frame_end) begin
        snap     <= bcd;
        lzb_snap <= lzb_en;
      end
      frame_tick <= frame_end;
      seg        <= cur_seg;
      an         <= (cnt < CNT_W'(BLANK_CYC)) ? '1 : ~(DIGITS'(1) << idx);
    end
  end

endmodule
